// File: rtl/s_p_stream.sv
// s_p_stream: serial-to-parallel ping-pong buffer for the FFT datapath.
//
// Collects N serial complex samples per frame into one of two register banks
// and emits the frame as S = N/LANES parallel words of LANES samples each.
// While one bank drains, the other fills, so input can run at one sample per
// cycle indefinitely as long as the downstream keeps accepting words.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_data holds a valid sample
//   in_ready   a sample can be accepted this cycle
//   in_data    serial sample, frame order x[0]..x[N-1]
//   out_valid  out_data holds a valid parallel word
//   out_ready  downstream accepts the word this cycle
//   out_data   parallel word, lane l in bits [(l+1)*DW-1:l*DW]
//   out_first  high with word 0 of a frame
//   out_last   high with word S-1 of a frame
//
// ORDER = 0: lane l of word j = x[j + l*S]  (strided)
// ORDER = 1: lane l of word j = x[j*LANES + l]  (contiguous)

module s_p_stream #(
    parameter int unsigned DW    = 34,
    parameter int unsigned N     = 16,
    parameter int unsigned LANES = 4,
    parameter int unsigned ORDER = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_data,
    output logic                  out_first,
    output logic                  out_last
);

    localparam int unsigned S  = N / LANES;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned RW = $clog2(S);

    // Bank storage is never reset; the full flags decide what is meaningful.
    logic [DW-1:0]        r_bank [2][N];
    logic [1:0]           r_full;
    logic                 r_wr_bank;
    logic [IW-1:0]        r_wr_idx;
    logic                 r_rd_bank;
    logic [RW-1:0]        r_rd_idx;

    logic                 w_wr_fire;
    logic                 w_wr_done;
    logic                 w_rd_fire;
    logic                 w_rd_done;
    logic [IW-1:0]        w_sel;
    logic [LANES*DW-1:0]  w_out_data;

    // Handshake status depends only on registered state.
    assign in_ready  = ~r_full[r_wr_bank];
    assign out_valid = r_full[r_rd_bank];
    assign out_first = out_valid && (r_rd_idx == '0);
    assign out_last  = out_valid && (r_rd_idx == RW'(S - 1));
    assign out_data  = w_out_data;

    assign w_wr_fire = in_valid && in_ready;
    assign w_wr_done = w_wr_fire && (r_wr_idx == IW'(N - 1));
    assign w_rd_fire = out_valid && out_ready;
    assign w_rd_done = w_rd_fire && (r_rd_idx == RW'(S - 1));

    // Lane gather from the draining bank; zero while no word is presented.
    always_comb begin
        w_out_data = '0;
        w_sel      = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            if (ORDER == 0) begin
                w_sel = IW'(r_rd_idx) + IW'(l * S);
            end else begin
                w_sel = IW'(int'(r_rd_idx) * int'(LANES) + l);
            end
            w_out_data[l*DW +: DW] = r_bank[r_rd_bank][w_sel];
        end
        if (!out_valid) begin
            w_out_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_bank[r_wr_bank][r_wr_idx] <= in_data;
        end
    end

    // Writer sets full on the bank it just filled; reader clears the bank it
    // just drained. Those are never the same bank in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_wr_idx  <= '0;
            r_rd_bank <= 1'b0;
            r_rd_idx  <= '0;
        end else begin
            if (w_wr_fire) begin
                if (w_wr_done) begin
                    r_wr_idx  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                    r_full[r_wr_bank] <= 1'b1;
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end
            if (w_rd_fire) begin
                if (w_rd_done) begin
                    r_rd_idx  <= '0;
                    r_rd_bank <= ~r_rd_bank;
                    r_full[r_rd_bank] <= 1'b0;
                end else begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_s_p_stream.sv
// Self-checking bench for s_p_stream: two instances (strided and contiguous
// ordering) share all inputs; a directed table covers the basic frame and a
// scoreboard covers streaming, backpressure, reset and random handshakes.

module tb_s_p_stream;

    localparam int unsigned DW    = 34;
    localparam int unsigned N     = 16;
    localparam int unsigned LANES = 4;
    localparam int unsigned S     = N / LANES;
    localparam int unsigned LW    = LANES * DW;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic           out_ready;

    logic           in_ready_s, out_valid_s, out_first_s, out_last_s;
    logic [LW-1:0]  out_data_s;
    logic           in_ready_c, out_valid_c, out_first_c, out_last_c;
    logic [LW-1:0]  out_data_c;

    s_p_stream #(.DW(DW), .N(N), .LANES(LANES), .ORDER(0)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_data),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_data_s),
        .out_first (out_first_s),
        .out_last  (out_last_s)
    );

    s_p_stream #(.DW(DW), .N(N), .LANES(LANES), .ORDER(1)) dut_c (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_c),
        .in_data   (in_data),
        .out_valid (out_valid_c),
        .out_ready (out_ready),
        .out_data  (out_data_c),
        .out_first (out_first_c),
        .out_last  (out_last_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] pack4(input logic [DW-1:0] l3, input logic [DW-1:0] l2,
                                            input logic [DW-1:0] l1, input logic [DW-1:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    // Scoreboard state
    typedef struct packed {
        logic [LW-1:0] ds;
        logic [LW-1:0] dc;
        logic          f;
        logic          l;
    } word_t;

    word_t          exp_q[$];
    logic [DW-1:0]  part[$];
    logic           prev_stall;
    logic [LW-1:0]  prev_ds, prev_dc;
    logic           prev_f, prev_l;
    int             words_seen;

    task automatic build_frame();
        for (int j = 0; j < int'(S); j++) begin
            word_t w;
            w.ds = '0;
            w.dc = '0;
            for (int l = 0; l < int'(LANES); l++) begin
                w.ds[l*DW +: DW] = part[j + l*S];
                w.dc[l*DW +: DW] = part[j*LANES + l];
            end
            w.f = (j == 0);
            w.l = (j == int'(S) - 1);
            exp_q.push_back(w);
        end
        part.delete();
    endtask

    // One cycle: sample outputs at the falling edge, score them, then drive.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, output logic acc);
        int pend;
        word_t e;
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_data_s", out_data_s, prev_ds);
            chk("stall_data_c", out_data_c, prev_dc);
            chk("stall_first", out_first_s, prev_f);
            chk("stall_last", out_last_s, prev_l);
        end
        pend = (exp_q.size() + S - 1) / S;
        chk("out_valid_s", out_valid_s, exp_q.size() != 0);
        chk("out_valid_c", out_valid_c, exp_q.size() != 0);
        chk("in_ready_s", in_ready_s, pend < 2);
        if (out_valid_s && r && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("word_s", out_data_s, e.ds);
            chk("word_c", out_data_c, e.dc);
            chk("first", out_first_s, e.f);
            chk("last", out_last_s, e.l);
            words_seen++;
        end
        prev_stall = out_valid_s && !r;
        prev_ds    = out_data_s;
        prev_dc    = out_data_c;
        prev_f     = out_first_s;
        prev_l     = out_last_s;
        acc = v && in_ready_s;
        if (acc) begin
            part.push_back(d);
            if (part.size() == N) build_frame();
        end
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready_s, 1'b1);
        chk("rst_out_valid", out_valid_s, 1'b0);
        chk("rst_out_first", out_first_s, 1'b0);
        chk("rst_out_last", out_last_s, 1'b0);
        chk("rst_out_data", out_data_s, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        part.delete();
        prev_stall = 1'b0;
        words_seen = 0;
    endtask

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        logic          e_ir;
        logic          e_ov;
        logic [LW-1:0] e_ds;
        logic [LW-1:0] e_dc;
        logic          e_f;
        logic          e_l;
    } vec_t;

    vec_t tbl[21];

    initial begin
        logic          acc;
        int            k;
        int            total;
        int            cyc;
        logic [63:0]   rnd;
        logic [LW-1:0] ws[4];
        logic [LW-1:0] wc[4];

        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        prev_stall = 1'b0;
        words_seen = 0;

        // Basic frame, both orderings, hand-computed words
        ws[0] = pack4(12, 8, 4, 0);
        ws[1] = pack4(13, 9, 5, 1);
        ws[2] = pack4(14, 10, 6, 2);
        ws[3] = pack4(15, 11, 7, 3);
        wc[0] = pack4(3, 2, 1, 0);
        wc[1] = pack4(7, 6, 5, 4);
        wc[2] = pack4(11, 10, 9, 8);
        wc[3] = pack4(15, 14, 13, 12);
        for (int i = 0; i < 21; i++) begin
            tbl[i].v    = (i < 16);
            tbl[i].d    = (i < 16) ? DW'(i) : '0;
            tbl[i].r    = 1'b1;
            tbl[i].e_ir = 1'b1;
            tbl[i].e_ov = (i >= 16 && i < 20);
            tbl[i].e_ds = (i >= 16 && i < 20) ? ws[i-16] : '0;
            tbl[i].e_dc = (i >= 16 && i < 20) ? wc[i-16] : '0;
            tbl[i].e_f  = (i == 16);
            tbl[i].e_l  = (i == 19);
        end

        do_reset();
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), in_ready_s, tbl[i].e_ir);
            chk($sformatf("tbl%0d_out_valid", i), out_valid_s, tbl[i].e_ov);
            chk($sformatf("tbl%0d_data_s", i), out_data_s, tbl[i].e_ds);
            chk($sformatf("tbl%0d_data_c", i), out_data_c, tbl[i].e_dc);
            chk($sformatf("tbl%0d_first", i), out_first_s, tbl[i].e_f);
            chk($sformatf("tbl%0d_last", i), out_last_s, tbl[i].e_l);
            in_valid  = tbl[i].v;
            in_data   = tbl[i].d;
            out_ready = tbl[i].r;
        end

        // Streaming: 8 back-to-back frames, in_ready must never drop
        do_reset();
        for (int f = 0; f < 8; f++) begin
            for (int s = 0; s < int'(N); s++) begin
                step(1'b1, DW'(f * 16 + s), 1'b1, acc);
                chk("stream_accept", acc, 1'b1);
            end
        end
        repeat (6) step(1'b0, '0, 1'b1, acc);
        chk("stream_words", words_seen, 32);

        // Backpressure: out_ready low while offering 40 samples
        do_reset();
        k = 0;
        repeat (40) begin
            step(1'b1, DW'(k), 1'b0, acc);
            if (acc) k++;
        end
        chk("bp_accepted", k, 32);
        chk("bp_in_ready_low", in_ready_s, 1'b0);
        chk("bp_held_word", out_data_s, pack4(12, 8, 4, 0));
        chk("bp_held_first", out_first_s, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, acc);
            chk("bp_drain_in_ready", in_ready_s, 1'b0);
        end
        step(1'b0, '0, 1'b0, acc);
        chk("bp_in_ready_back", in_ready_s, 1'b1);
        for (int i = 32; i < 40; i++) step(1'b1, DW'(i), 1'b0, acc);
        // Reset with frame 1 pending on the output
        do_reset();

        // Reset mid-frame: sample 9 accepted, then a fresh frame 100..115
        for (int i = 0; i < 10; i++) step(1'b1, DW'(i), 1'b1, acc);
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, DW'(100 + i), 1'b1, acc);
        step(1'b0, '0, 1'b0, acc);
        chk("rst_frame_valid", out_valid_s, 1'b1);
        chk("rst_frame_word0", out_data_s, pack4(112, 108, 104, 100));
        repeat (6) step(1'b0, '0, 1'b1, acc);
        chk("rst_frame_words", words_seen, 4);

        // Random handshakes over 200 frames
        do_reset();
        total = 0;
        cyc   = 0;
        while (total < 200 * int'(N) && cyc < 40000) begin
            rnd = {$urandom, $urandom};
            step(1'($urandom_range(0, 1)), rnd[DW-1:0], 1'($urandom_range(0, 1)), acc);
            if (acc) total++;
            cyc++;
        end
        chk("rand_accepted", total, 200 * N);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            step(1'b0, '0, 1'b1, acc);
            cyc++;
        end
        step(1'b0, '0, 1'b1, acc);
        chk("rand_words", words_seen, 200 * S);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
